if_stage: RTL and testbench

- Instruction-fetch stage of the MIPS core: holds the PC, issues one-outstanding-request fetches to the I-cache, and loads the IF/ID register.
- The IF/ID register supplies the `op` field to the main decoder and the instruction to the ID stage.
- Supports ID stall, and redirect for beq/j resolved in ID. No branch delay slot: wrong-path fetches are squashed.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/if_id_reg.sv | 49 ++++
 rtl/if_stage_chk.sv | 22 ++
 rtl/if_stage.sv | 169 ++++++++++++++++
 tb/tb_if_stage.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the MIPS core.
//   - Reset/NOP defaults for the fetch stage.
//   - Primary opcode constants, shared with the main decoder.
//   - State encoding of the if_stage fetch FSM.
//   - Small PC arithmetic helpers.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,  // request presented to the I-cache
        IF_WAIT  = 2'd1,  // request accepted, waiting for the response
        IF_HOLD  = 2'd2,  // response parked in the hold buffer while ID stalls
        IF_DROP  = 2'd3   // wrong-path response still in flight, discard it
    } if_state_e;

    // Sequential successor address, modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a target address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst            clock, asynchronous active-high reset
//   flush               squash the slot (redirect); highest priority
//   load                write load_instr/load_pc4 as a valid instruction
//   stall               ID cannot accept: hold the current contents
//   load_instr/pc4      instruction word and its address + 4
//   id_valid/instr/pc4  registered slot contents seen by ID
// With no load, no flush and no stall the slot becomes a bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        stall,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc4,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4
);

    // Slot update: flush > load > stall hold > bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc4   <= 32'd0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (load) begin
            id_valid <= 1'b1;
            id_instr <= load_instr;
            id_pc4   <= load_pc4;
        end else if (stall) begin
            id_valid <= id_valid;
            id_instr <= id_instr;
            id_pc4   <= id_pc4;
        end else begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_stage_chk.sv
// if_stage_chk: simulation-only protocol checks for if_stage.
//   clk, rst       clock and reset of the checked stage
//   icache_valid   cache response strobe
//   state          current fetch FSM state
// A response is only legal while a request is outstanding (WAIT or DROP).
module if_stage_chk
    import cpu_pkg::*;
(
    input logic      clk,
    input logic      rst,
    input logic      icache_valid,
    input if_state_e state
);

    // Flag a cache response that arrives with no request outstanding.
    always @(posedge clk) begin
        if (!rst && icache_valid) begin
            assert (state == IF_WAIT || state == IF_DROP);
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with a single outstanding I-cache request.
//   clk, rst                      clock, asynchronous active-high reset
//   icache_req/addr/ready         request handshake (addr word aligned)
//   icache_valid/rdata            response, one pulse per accepted request
//   stall                         ID cannot take a new instruction
//   redirect_valid/pc             taken beq/j resolved in ID
//   id_valid/id_instr/id_pc4      IF/ID register contents
// No delay slot: any fetch in flight when a redirect arrives is squashed.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_valid,
    input  logic [31:0] icache_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4
);

    if_state_e   state_r;
    logic [31:0] pc_r;
    logic [31:0] fetch_pc_r;
    logic [31:0] hold_buf_r;
    logic        req_r;
    logic [31:0] addr_r;

    if_state_e   state_nxt_s;
    logic [31:0] pc_nxt_s;
    logic [31:0] target_s;
    logic        accept_s;
    logic        latch_fetch_s;
    logic        capture_s;
    logic        load_s;
    logic [31:0] load_instr_s;
    logic [31:0] load_pc4_s;

    assign target_s    = word_align(redirect_pc);
    // req_r is only ever set for the FETCH state, so it qualifies the handshake.
    assign accept_s    = req_r & icache_ready;
    assign load_pc4_s  = pc_plus4(fetch_pc_r);
    assign icache_req  = req_r;
    assign icache_addr = addr_r;

    // Next-state, next-PC and IF/ID load decisions; redirect wins in every state.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        latch_fetch_s = 1'b0;
        capture_s     = 1'b0;
        load_s        = 1'b0;
        load_instr_s  = hold_buf_r;
        case (state_r)
            IF_FETCH: begin
                if (redirect_valid) begin
                    pc_nxt_s    = target_s;
                    // A request accepted this cycle is wrong-path; its reply must be eaten.
                    state_nxt_s = accept_s ? IF_DROP : IF_FETCH;
                end else if (accept_s) begin
                    latch_fetch_s = 1'b1;
                    state_nxt_s   = IF_WAIT;
                end else begin
                    state_nxt_s = IF_FETCH;
                end
            end
            IF_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt_s    = target_s;
                    state_nxt_s = icache_valid ? IF_FETCH : IF_DROP;
                end else if (icache_valid) begin
                    if (!stall) begin
                        load_s       = 1'b1;
                        load_instr_s = icache_rdata;
                        pc_nxt_s     = load_pc4_s;
                        state_nxt_s  = IF_FETCH;
                    end else begin
                        capture_s   = 1'b1;
                        state_nxt_s = IF_HOLD;
                    end
                end else begin
                    state_nxt_s = IF_WAIT;
                end
            end
            IF_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt_s    = target_s;
                    state_nxt_s = IF_FETCH;
                end else if (!stall) begin
                    load_s      = 1'b1;
                    pc_nxt_s    = load_pc4_s;
                    state_nxt_s = IF_FETCH;
                end else begin
                    state_nxt_s = IF_HOLD;
                end
            end
            IF_DROP: begin
                if (redirect_valid) begin
                    pc_nxt_s    = target_s;
                    // If the stale reply lands in this same cycle nothing is left in
                    // flight, so waiting longer in DROP would never terminate.
                    state_nxt_s = icache_valid ? IF_FETCH : IF_DROP;
                end else if (icache_valid) begin
                    state_nxt_s = IF_FETCH;
                end else begin
                    state_nxt_s = IF_DROP;
                end
            end
            default: begin
                state_nxt_s = IF_FETCH;
                pc_nxt_s    = pc_r;
            end
        endcase
    end

    // FSM, PC and registered cache request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IF_FETCH;
            pc_r       <= RESET_PC;
            fetch_pc_r <= RESET_PC;
            hold_buf_r <= NOP_INSTR;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            req_r   <= (state_nxt_s == IF_FETCH);
            addr_r  <= pc_nxt_s;
            if (latch_fetch_s) begin
                fetch_pc_r <= pc_r;
            end
            if (capture_s) begin
                hold_buf_r <= icache_rdata;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (load_s),
        .stall      (stall),
        .load_instr (load_instr_s),
        .load_pc4   (load_pc4_s),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc4     (id_pc4)
    );

    if_stage_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .icache_valid (icache_valid),
        .state        (state_r)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage with a behavioural I-cache
// (random ready, 1..3 cycle latency) and a program-order reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_valid;
    logic [31:0] icache_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;

    int total = 0;
    int bad   = 0;

    // cache model state
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    int          pend_cnt   = 0;
    bit          ovr_en     = 1'b0;
    logic [31:0] ovr_data   = 32'h0;

    // events observed in the most recent step
    bit          ev_accept;
    bit          ev_overlap;
    bit          ev_consume;
    logic [31:0] ev_addr;
    logic        ev_idv;
    logic [31:0] ev_instr;
    logic [31:0] ev_pc4;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_ready   (icache_ready),
        .icache_valid   (icache_valid),
        .icache_rdata   (icache_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc4         (id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_3C3C;
    endfunction

    // One clock cycle: cache response, new inputs, and event capture at the negedge.
    task automatic step(input bit rdy, input bit stl, input bit rdv, input logic [31:0] rpc, input int lat);
        @(negedge clk);
        icache_valid = 1'b0;
        icache_rdata = 32'h0;
        if (pend_valid) begin
            if (pend_cnt == 0) begin
                icache_valid = 1'b1;
                icache_rdata = ovr_en ? ovr_data : mem_word(pend_addr);
                ovr_en       = 1'b0;
                pend_valid   = 1'b0;
            end else begin
                pend_cnt = pend_cnt - 1;
            end
        end
        icache_ready   = rdy;
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        ev_accept  = icache_req && rdy;
        ev_overlap = ev_accept && pend_valid;
        ev_addr    = icache_addr;
        ev_idv     = id_valid;
        ev_instr   = id_instr;
        ev_pc4     = id_pc4;
        ev_consume = id_valid && !stl;
        if (ev_accept) begin
            pend_valid = 1'b1;
            pend_addr  = icache_addr;
            pend_cnt   = lat - 1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        icache_ready = 1'b0; icache_valid = 1'b0; icache_rdata = 32'h0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        pend_valid = 1'b0; ovr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        icache_ready = 1'b0; icache_valid = 1'b0; icache_rdata = 32'h0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", icache_req); end
        total++; if (icache_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", icache_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%0h exp=0", id_valid); end
        total++; if (id_instr !== NOP) begin bad++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
        total++; if (id_pc4 !== 32'h0) begin bad++; $display("FAIL reset_id_pc4 got=%h exp=00000000", id_pc4); end
        apply_reset();
        #1;
        total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL release_req_low got=%0h exp=0", icache_req); end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (icache_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h exp=1", icache_req); end
        total++; if (icache_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=00000000", icache_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc4;
        int n_acc;
        int n_cons;
        bit exp_idv;
        apply_reset();
        exp_addr = 32'h0; exp_pc4 = 32'd4; n_acc = 0; n_cons = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            exp_idv = (k >= 3) && (k % 2 == 1);
            total++; if (ev_idv !== exp_idv) begin bad++; $display("FAIL seq_id_valid step=%0d got=%0h exp=%0h", k, ev_idv, exp_idv); end
            if (ev_accept) begin
                total++; if (ev_addr !== exp_addr) begin bad++; $display("FAIL seq_addr got=%h exp=%h", ev_addr, exp_addr); end
                exp_addr = exp_addr + 32'd4; n_acc++;
            end
            if (ev_consume) begin
                total++; if (ev_pc4 !== exp_pc4) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", ev_pc4, exp_pc4); end
                total++; if (ev_instr !== mem_word(exp_pc4 - 32'd4)) begin bad++; $display("FAIL seq_instr got=%h exp=%h", ev_instr, mem_word(exp_pc4 - 32'd4)); end
                exp_pc4 = exp_pc4 + 32'd4; n_cons++;
            end
        end
        total++; if (n_acc !== 5) begin bad++; $display("FAIL seq_accept_count got=%0d exp=5", n_acc); end
        total++; if (n_cons !== 4) begin bad++; $display("FAIL seq_deliver_count got=%0d exp=4", n_cons); end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1);
        total++; if (ev_idv !== 1'b1 || ev_pc4 !== 32'd4) begin bad++; $display("FAIL stall_first got=%0h/%h exp=1/00000004", ev_idv, ev_pc4); end
        ovr_en = 1'b1; ovr_data = 32'h8C01_0004;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, (k < 2), 1'b0, 32'h0, 1);
            total++; if (ev_idv !== 1'b1 || ev_instr !== mem_word(32'h0) || ev_pc4 !== 32'd4) begin
                bad++; $display("FAIL stall_held k=%0d got=%0h/%h/%h exp=1/%h/00000004", k, ev_idv, ev_instr, ev_pc4, mem_word(32'h0)); end
            total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL stall_no_req k=%0d got=%0h exp=0", k, icache_req); end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_idv !== 1'b1 || ev_instr !== 32'h8C01_0004) begin bad++; $display("FAIL stall_release_instr got=%0h/%h exp=1/8c010004", ev_idv, ev_instr); end
        total++; if (ev_pc4 !== 32'd8) begin bad++; $display("FAIL stall_release_pc4 got=%h exp=00000008", ev_pc4); end
        total++; if (icache_req !== 1'b1 || icache_addr !== 32'd8) begin bad++; $display("FAIL stall_next_req got=%0h/%h exp=1/00000008", icache_req, icache_addr); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 3);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_idv !== 1'b0) begin bad++; $display("FAIL rw_id_valid_after got=%0h exp=0", ev_idv); end
        total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL rw_req_drop got=%0h exp=0", icache_req); end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_accept !== 1'b1 || ev_addr !== 32'h40) begin bad++; $display("FAIL rw_target_addr got=%0h/%h exp=1/00000040", ev_accept, ev_addr); end
        total++; if (ev_idv !== 1'b0) begin bad++; $display("FAIL rw_dropped_reached_id got=%0h exp=0", ev_idv); end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_idv !== 1'b1 || ev_pc4 !== 32'h44 || ev_instr !== mem_word(32'h40)) begin
            bad++; $display("FAIL rw_target_deliver got=%0h/%h/%h exp=1/00000044/%h", ev_idv, ev_pc4, ev_instr, mem_word(32'h40)); end
    endtask

    task automatic test_redirect_accept();
        apply_reset();
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1);
        total++; if (ev_accept !== 1'b1) begin bad++; $display("FAIL ra_accept got=%0h exp=1", ev_accept); end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (icache_req !== 1'b0 || ev_idv !== 1'b0) begin bad++; $display("FAIL ra_drop got=%0h/%0h exp=0/0", icache_req, ev_idv); end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_accept !== 1'b1 || ev_addr !== 32'h100) begin bad++; $display("FAIL ra_target_addr got=%0h/%h exp=1/00000100", ev_accept, ev_addr); end
        total++; if (ev_idv !== 1'b0) begin bad++; $display("FAIL ra_wrong_path_id got=%0h exp=0", ev_idv); end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_idv !== 1'b1 || ev_pc4 !== 32'h104 || ev_instr !== mem_word(32'h100)) begin
            bad++; $display("FAIL ra_deliver got=%0h/%h/%h exp=1/00000104/%h", ev_idv, ev_pc4, ev_instr, mem_word(32'h100)); end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_accept !== 1'b1 || ev_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%0h/%h exp=1/fffffffc", ev_accept, ev_addr); end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_idv !== 1'b1 || ev_pc4 !== 32'h0 || ev_instr !== mem_word(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap_pc4 got=%0h/%h/%h exp=1/00000000/%h", ev_idv, ev_pc4, ev_instr, mem_word(32'hFFFF_FFFC)); end
        total++; if (icache_req !== 1'b1 || icache_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr got=%0h/%h exp=1/00000000", icache_req, icache_addr); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        total++; if (id_valid !== 1'b1 || id_pc4 !== 32'd4) begin bad++; $display("FAIL ar_pre got=%0h/%h exp=1/00000004", id_valid, id_pc4); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (icache_req !== 1'b0 || icache_addr !== 32'h0) begin bad++; $display("FAIL ar_req got=%0h/%h exp=0/00000000", icache_req, icache_addr); end
        total++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc4 !== 32'h0) begin
            bad++; $display("FAIL ar_id got=%0h/%h/%h exp=0/%h/00000000", id_valid, id_instr, id_pc4, NOP); end
        pend_valid = 1'b0;
        icache_valid = 1'b0; icache_ready = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (icache_req !== 1'b0) begin bad++; $display("FAIL ar_release_req got=%0h exp=0", icache_req); end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        total++; if (ev_accept !== 1'b1 || ev_addr !== 32'h0) begin bad++; $display("FAIL ar_first_fetch got=%0h/%h exp=1/00000000", ev_accept, ev_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_fetch;
        logic [31:0] exp_pc4;
        logic [31:0] rpc;
        bit rdy, stl, rdv;
        bit prev_stl, prev_rdv;
        logic prev_idv;
        logic [31:0] prev_instr, prev_pc4;
        int n_cons;
        apply_reset();
        exp_fetch = 32'h0; exp_pc4 = 32'd4; n_cons = 0;
        prev_stl = 1'b0; prev_rdv = 1'b0; prev_idv = 1'b0; prev_instr = NOP; prev_pc4 = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 3) == 0);
            rdv = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            step(rdy, stl, rdv, rpc, $urandom_range(1, 3));
            if (ev_accept) begin
                total++; if (ev_overlap !== 1'b0) begin bad++; $display("FAIL rnd_two_outstanding cyc=%0d got=1 exp=0", i); end
                if (!rdv) begin
                    total++; if (ev_addr !== exp_fetch) begin bad++; $display("FAIL rnd_fetch_addr cyc=%0d got=%h exp=%h", i, ev_addr, exp_fetch); end
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
            if (ev_consume) begin
                total++; if (ev_pc4 !== exp_pc4) begin bad++; $display("FAIL rnd_pc4 cyc=%0d got=%h exp=%h", i, ev_pc4, exp_pc4); end
                total++; if (ev_instr !== mem_word(exp_pc4 - 32'd4)) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, ev_instr, mem_word(exp_pc4 - 32'd4)); end
                exp_pc4 = exp_pc4 + 32'd4;
                n_cons++;
            end
            if (!ev_idv) begin
                total++; if (ev_instr !== NOP) begin bad++; $display("FAIL rnd_bubble_nop cyc=%0d got=%h exp=%h", i, ev_instr, NOP); end
            end
            if (prev_stl && !prev_rdv) begin
                total++; if (ev_idv !== prev_idv || ev_instr !== prev_instr || ev_pc4 !== prev_pc4) begin
                    bad++; $display("FAIL rnd_stall_hold cyc=%0d got=%0h/%h/%h exp=%0h/%h/%h", i, ev_idv, ev_instr, ev_pc4, prev_idv, prev_instr, prev_pc4); end
            end
            if (rdv) begin
                exp_fetch = rpc & 32'hFFFF_FFFC;
                exp_pc4   = (rpc & 32'hFFFF_FFFC) + 32'd4;
            end
            prev_stl = stl; prev_rdv = rdv;
            prev_idv = ev_idv; prev_instr = ev_instr; prev_pc4 = ev_pc4;
        end
        total++; if (n_cons < 150) begin bad++; $display("FAIL rnd_progress got=%0d exp>=150", n_cons); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_accept();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
